// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for the single-cycle core.
// Sequences BOOT -> RUN -> HALT, computes the next PC from the core's
// branch/zero/immediate feedback, and counts retired instructions.
module pc_fetch_unit #(
  parameter int unsigned             ADDR_WIDTH  = 48,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
  parameter int unsigned             IMEM_BYTES  = 256,
  parameter int unsigned             BOOT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch,
  input  logic                  zero,
  input  logic [63:0]           imm,
  input  logic                  halt_req,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  valid,
  output logic                  halted,
  output logic                  fault,
  output logic [31:0]           instr_count
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [BW-1:0]         boot_cnt_q, boot_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  fault_q, fault_d;
  logic [31:0]           count_q, count_d;

  logic                  taken;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [31:0]           count_inc;

  // Immediate bits above the address width cannot affect a wrapped sum.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[63:ADDR_WIDTH-1];

  // Next-PC datapath: halfword immediate scaled to bytes, sum wraps at ADDR_WIDTH.
  always_comb begin
    taken     = branch & zero;
    offset    = taken ? {imm[ADDR_WIDTH-2:0], 1'b0} : ADDR_WIDTH'(4);
    next_pc   = addr_q + offset;
    count_inc = (count_q == '1) ? count_q : count_q + 32'd1;
  end

  // Sequencer: priority halt_req > stall > misaligned target > out-of-range > advance.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    addr_d     = addr_q;
    fault_d    = fault_q;
    count_d    = count_q;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 1'b1;
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          count_d = count_inc;
          if (taken && (next_pc[1:0] != 2'b00)) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else if (next_pc >= ADDR_WIDTH'(IMEM_BYTES)) begin
            state_d = ST_HALT;
          end else begin
            addr_d = next_pc;
          end
        end
      end
      ST_HALT: ;
      default: state_d = ST_HALT;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      addr_q     <= RESET_PC;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      addr_q     <= addr_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign address     = addr_q;
  assign fault       = fault_q;
  assign instr_count = count_q;
  assign valid       = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a model.
module tb_pc_fetch_unit;

  localparam int unsigned AW    = 48;
  localparam int unsigned IMEM  = 256;
  localparam int unsigned BOOTC = 2;
  localparam longint unsigned MASK = (64'd1 << AW) - 64'd1;

  logic          clk;
  logic          reset;
  logic          stall, branch, zero, halt_req;
  logic [63:0]   imm;
  logic [AW-1:0] address;
  logic          valid, halted, fault;
  logic [31:0]   instr_count;

  pc_fetch_unit #(
    .ADDR_WIDTH (AW),
    .RESET_PC   ('0),
    .IMEM_BYTES (IMEM),
    .BOOT_CYCLES(BOOTC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .branch     (branch),
    .zero       (zero),
    .imm        (imm),
    .halt_req   (halt_req),
    .address    (address),
    .valid      (valid),
    .halted     (halted),
    .fault      (fault),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, PC, retired count, fault flag.
  typedef enum int {M_BOOT, M_RUN, M_HALT} mphase_t;
  mphase_t         m_ph;
  int              m_boot_done;
  longint unsigned m_addr;
  longint unsigned m_cnt;
  bit              m_fault;

  always @(posedge clk or posedge reset) begin
    longint unsigned nxt;
    bit tk;
    if (reset) begin
      m_ph = M_BOOT; m_boot_done = 0; m_addr = 0; m_cnt = 0; m_fault = 0;
    end else begin
      case (m_ph)
        M_BOOT: begin
          m_boot_done++;
          if (m_boot_done == BOOTC) m_ph = M_RUN;
        end
        M_RUN: begin
          if (halt_req) m_ph = M_HALT;
          else if (!stall) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            tk  = branch && zero;
            nxt = tk ? ((m_addr + (imm << 1)) & MASK) : ((m_addr + 4) & MASK);
            if (tk && (nxt % 4 != 0)) begin
              m_ph = M_HALT; m_fault = 1;
            end else if (nxt >= IMEM) begin
              m_ph = M_HALT;
            end else begin
              m_addr = nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("addr",  address, m_addr);
      chk("valid", valid,  (m_ph == M_RUN));
      chk("halted",halted, (m_ph == M_HALT));
      chk("fault", fault,  m_fault);
      chk("count", instr_count, m_cnt);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_in();
    stall = 0; branch = 0; zero = 0; halt_req = 0; imm = '0;
  endtask

  // Reset held across one rising edge, released on a falling edge.
  task automatic do_reset();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic boot_to_run();
    do_reset();
    cyc(); cyc();
  endtask

  initial begin
    idle_in();
    reset = 1;
    cyc();
    chk_en = 1;
    reset = 0;

    // Boot timing and sequential fetch.
    chk("boot_addr", address, 0);
    chk("boot_valid0", valid, 0);
    cyc();
    chk("boot_valid1", valid, 0);
    cyc();
    chk("run_valid", valid, 1);
    chk("run_addr0", address, 0);
    cyc(); chk("seq4", address, 4);
    cyc(); chk("seq8", address, 8);
    cyc(); chk("seq12", address, 12);
    chk("cnt3", instr_count, 3);
    cyc(); chk("seq16", address, 16);

    // Taken backward branch, then not-taken branch.
    branch = 1; zero = 1; imm = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(); chk("br_taken", address, 64'h08);
    idle_in();
    cyc(); cyc(); chk("pre_nt", address, 64'h10);
    branch = 1; zero = 0; imm = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(); chk("br_nt", address, 64'h14);
    chk("cnt8", instr_count, 8);
    idle_in();

    // Stall hold.
    cyc(); cyc(); cyc();
    chk("pre_stall", address, 64'h20);
    stall = 1; branch = 1; zero = 1; imm = 64'd8;
    cyc(); cyc(); cyc();
    chk("stall_addr", address, 64'h20);
    chk("stall_cnt", instr_count, 11);
    idle_in();
    cyc(); chk("unstall", address, 64'h24);
    chk("cnt12", instr_count, 12);

    // Asynchronous reset between edges.
    cyc(); cyc(); cyc();
    chk("pre_arst", address, 64'h30);
    #2 reset = 1;
    #1;
    chk("arst_addr", address, 0);
    chk("arst_cnt", instr_count, 0);
    chk("arst_valid", valid, 0);
    cyc();
    reset = 0;
    cyc(); cyc();
    chk("reboot_valid", valid, 1);

    // halt_req beats stall.
    halt_req = 1; stall = 1;
    cyc();
    chk("hs_halted", halted, 1);
    chk("hs_valid", valid, 0);
    chk("hs_cnt", instr_count, 0);
    idle_in();

    // Run off the end of instruction memory.
    boot_to_run();
    branch = 1; zero = 1; imm = 64'h7E;
    cyc(); chk("jump_fc", address, 64'hFC);
    idle_in();
    cyc();
    chk("oob_halted", halted, 1);
    chk("oob_valid", valid, 0);
    chk("oob_fault", fault, 0);
    chk("oob_addr", address, 64'hFC);
    chk("oob_cnt", instr_count, 2);
    cyc(); cyc();
    chk("oob_cnt_frz", instr_count, 2);

    // Misaligned taken target.
    boot_to_run();
    branch = 1; zero = 1; imm = 64'h20;
    cyc(); chk("jump_40", address, 64'h40);
    imm = 64'd1;
    cyc();
    chk("mis_halted", halted, 1);
    chk("mis_fault", fault, 1);
    chk("mis_addr", address, 64'h40);
    chk("mis_cnt", instr_count, 2);
    halt_req = 1; stall = 1; imm = 64'd4;
    cyc();
    halt_req = 0; stall = 0;
    cyc(); cyc();
    chk("mis_frz_addr", address, 64'h40);
    chk("mis_frz_fault", fault, 1);
    chk("mis_frz_cnt", instr_count, 2);
    idle_in();

    // Backward branch wrapping below zero halts without fault.
    boot_to_run();
    branch = 1; zero = 1; imm = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc();
    chk("wrap_halted", halted, 1);
    chk("wrap_fault", fault, 0);
    chk("wrap_addr", address, 0);
    idle_in();

    // Randomized phase.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      longint v;
      stall    = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 39) == 0);
      branch   = $urandom_range(0, 1);
      zero     = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel == 0)      v = longint'($urandom_range(0, 20)) - 10;
      else if (sel == 1) v = -longint'($urandom_range(0, 1000)) * 2;
      else               v = (longint'($urandom_range(0, 40)) - 20) * 2;
      imm = v;
      if ((m_ph == M_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 4)) reset = 1;
        cyc();
        reset = 0;
      end else begin
        cyc();
      end
    end

    idle_in();
    cyc();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
